audio_capture_controller: RTL and testbench
===========================================

// Module: audio_capture_controller
// PURPOSE
//  Sequences capture of downscaled audio samples into a frame-buffer BRAM. Sits after the
//  I2S downscaler: arms on a start pulse, optionally waits for a rising level-crossing trigger,
//  then writes DEPTH samples (with optional decimation) and signals done. Feeds FFT/display.
// PARAMETERS
//  SAMPLE_DATA_WIDTH  8     signed sample width, matches downscaler output
//  DEPTH              1024  samples per frame; power of two, >=4
//  DECIM_WIDTH        8     width of decimation factor input
// PORTS
//  clk           in   1                   system clock
//  rst           in   1                   synchronous, active-high reset
//  start         in   1                   1-cycle pulse: begin capture (ignored unless IDLE)
//  abort         in   1                   1-cycle pulse: cancel capture, return to IDLE
//  trig_enable   in   1                   sampled at start: 1 = wait for trigger, 0 = free-run
//  trig_level    in   SAMPLE_DATA_WIDTH   signed trigger threshold, sampled at start
//  decim         in   DECIM_WIDTH         keep 1 of every decim samples; 0 treated as 1; sampled at start
//  sample_valid  in   1                   1-cycle strobe from downscaler (axiov)
//  sample_data   in   SAMPLE_DATA_WIDTH   signed sample (axiod), valid with sample_valid
//  bram_we       out  1                   BRAM write enable
//  bram_addr     out  $clog2(DEPTH)       BRAM write address
//  bram_din      out  SAMPLE_DATA_WIDTH   BRAM write data
//  busy          out  1                   high in ARMED or CAPTURE
//  done          out  1                   1-cycle pulse after last write of a frame
//  frame_count   out  16                  completed frames since reset, wraps at 2^16
// BEHAVIOUR
//  - Reset: state IDLE; bram_we=0, bram_addr=0, bram_din=0, busy=0, done=0, frame_count=0.
//  - States: IDLE -> (start) ARMED if trig_enable else CAPTURE; ARMED -> (trigger) CAPTURE;
//    CAPTURE -> (write at addr DEPTH-1) DONE; DONE -> IDLE unconditionally next cycle.
//  - start latches trig_enable, trig_level, decim; decim counter cleared; addr cleared to 0.
//  - Trigger: prev < trig_level && cur >= trig_level (signed), over consecutive valid samples.
//    prev cleared to most-negative value on entry to ARMED, so first sample >= level triggers.
//    Triggering sample is written at addr 0 (counts as decimation phase 0).
//  - Decimation: in CAPTURE, samples counted modulo decim; only phase-0 samples written.
//  - Write latency: bram_we/bram_addr/bram_din registered, valid 1 cycle after sample_valid.
//    bram_we never high for more than 1 cycle per accepted sample. addr increments after each write.
//  - DONE: done=1 for exactly that cycle, frame_count++; busy low. start in DONE ignored.
//  - abort (any non-IDLE state) -> IDLE next cycle; no done, frame_count unchanged, pending write
//    in flight that cycle still completes. abort and start same cycle in IDLE: abort wins.
//  - sample_valid in IDLE/DONE ignored. start while busy ignored.
//  - Arithmetic: trigger compare signed, full SAMPLE_DATA_WIDTH; addr wraps never (stop at DEPTH-1).
// STRUCTURE
//  - audio_capture_pkg: capture_state_t enum {IDLE, ARMED, CAPTURE, DONE}; shared DEPTH default,
//    SAMPLE_DATA_WIDTH default.
//  - Sub-module trigger_detector: holds prev sample, level, outputs 1-cycle 'fire' on crossing;
//    clear input for ARMED entry.
// TESTING
//  - Free-run: trig_enable=0, decim=1, DEPTH=8, 8 ramp samples 0..7 -> writes addr 0..7 data 0..7,
//    done pulse 1 cycle after 8th write, frame_count=1.
//  - Trigger: level=10, samples -5,5,9,12,20 -> no writes until 12; 12 written at addr 0, 20 at addr 1.
//  - Decim=3, free-run: samples 0..23 -> writes 0,3,6,...,21 at addr 0..7; decim=0 behaves as 1.
//  - Abort mid-CAPTURE after 3 writes -> IDLE, busy=0, no done, frame_count unchanged; next start
//    restarts at addr 0.
//  - start pulses during ARMED/CAPTURE and sample_valid in IDLE -> no effect, no bram_we.
//  - Reset asserted mid-CAPTURE -> all outputs to reset values next cycle, frame_count=0.

Source files
------------

// File: rtl/audio_capture_pkg.sv
// Shared types and default sizes for the audio capture path.
package audio_capture_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } capture_state_t;

   localparam int DEFAULT_DEPTH             = 1024;
   localparam int DEFAULT_SAMPLE_DATA_WIDTH = 8;

endpackage

// File: rtl/trigger_detector.sv
// Rising level-crossing detector: fires combinationally on the sample that crosses the level.
module trigger_detector
   import audio_capture_pkg::*;
#(
   parameter int SAMPLE_DATA_WIDTH = DEFAULT_SAMPLE_DATA_WIDTH
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                clear,
   input  logic signed [SAMPLE_DATA_WIDTH-1:0] level,
   input  logic                                sample_valid,
   input  logic signed [SAMPLE_DATA_WIDTH-1:0] sample_data,
   output logic                                fire
);

   localparam logic signed [SAMPLE_DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(SAMPLE_DATA_WIDTH-1){1'b0}}};

   logic signed [SAMPLE_DATA_WIDTH-1:0] prev_p0;
   logic signed [SAMPLE_DATA_WIDTH-1:0] level_p0;

   // clear seeds prev with the most negative value so an initial sample at or above level fires
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_p0  <= MOST_NEG;
         level_p0 <= '0;
      end else if (clear) begin
         prev_p0  <= MOST_NEG;
         level_p0 <= level;
      end else if (sample_valid) begin
         prev_p0  <= sample_data;
      end
   end

   assign fire = sample_valid && (prev_p0 < level_p0) && (sample_data >= level_p0);

endmodule

// File: rtl/audio_capture_controller.sv
// Frame capture sequencer: arms on start, optionally waits for a trigger, then writes
// DEPTH decimated samples into the frame buffer and pulses done.
module audio_capture_controller
   import audio_capture_pkg::*;
#(
   parameter int SAMPLE_DATA_WIDTH = DEFAULT_SAMPLE_DATA_WIDTH,
   parameter int DEPTH             = DEFAULT_DEPTH,
   parameter int DECIM_WIDTH       = 8
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                start,
   input  logic                                abort,
   input  logic                                trig_enable,
   input  logic signed [SAMPLE_DATA_WIDTH-1:0] trig_level,
   input  logic [DECIM_WIDTH-1:0]              decim,
   input  logic                                sample_valid,
   input  logic signed [SAMPLE_DATA_WIDTH-1:0] sample_data,
   output logic                                bram_we,
   output logic [$clog2(DEPTH)-1:0]            bram_addr,
   output logic signed [SAMPLE_DATA_WIDTH-1:0] bram_din,
   output logic                                busy,
   output logic                                done,
   output logic [15:0]                         frame_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   capture_state_t state, state_next;

   logic                   start_ok;
   logic                   fire;
   logic                   trig_take;
   logic                   capture_take;
   logic                   accept;
   logic [DECIM_WIDTH-1:0] decim_q;
   logic [DECIM_WIDTH-1:0] phase;
   logic [AW-1:0]          addr;
   logic                   full;

   function automatic logic [DECIM_WIDTH-1:0] next_phase(input logic [DECIM_WIDTH-1:0] ph,
                                                         input logic [DECIM_WIDTH-1:0] dec);
      return (ph == dec - DECIM_WIDTH'(1)) ? '0 : ph + DECIM_WIDTH'(1);
   endfunction

   assign start_ok     = (state == IDLE) && start && !abort;
   assign trig_take    = (state == ARMED) && fire;
   assign capture_take = (state == CAPTURE) && sample_valid && !full;
   assign accept       = trig_take || (capture_take && (phase == '0));

   trigger_detector #(
      .SAMPLE_DATA_WIDTH(SAMPLE_DATA_WIDTH)
   ) u_trig (
      .clk         (clk),
      .rst         (rst),
      .clear       (start_ok && trig_enable),
      .level       (trig_level),
      .sample_valid(sample_valid),
      .sample_data (sample_data),
      .fire        (fire)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // CAPTURE leaves only once the final write is on the bus, so done trails it by one cycle
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start_ok) state_next = trig_enable ? ARMED : CAPTURE;
         ARMED:   if (abort) state_next = IDLE;
                  else if (fire) state_next = CAPTURE;
         CAPTURE: if (abort) state_next = IDLE;
                  else if (full) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == ARMED) || (state == CAPTURE);
      done = (state == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         decim_q     <= DECIM_WIDTH'(1);
         phase       <= '0;
         addr        <= '0;
         full        <= 1'b0;
         bram_we     <= 1'b0;
         bram_addr   <= '0;
         bram_din    <= '0;
         frame_count <= '0;
      end else begin
         bram_we <= accept;
         if (accept) begin
            bram_addr <= addr;
            bram_din  <= sample_data;
         end
         if (start_ok) begin
            decim_q <= (decim == '0) ? DECIM_WIDTH'(1) : decim;
            phase   <= '0;
            addr    <= '0;
            full    <= 1'b0;
         end else begin
            // the triggering sample is decimation phase 0
            if (trig_take)         phase <= next_phase('0, decim_q);
            else if (capture_take) phase <= next_phase(phase, decim_q);
            if (accept) begin
               if (addr == LAST_ADDR) full <= 1'b1;
               else                   addr <= addr + AW'(1);
            end
         end
         if ((state == CAPTURE) && full && !abort) frame_count <= frame_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_audio_capture_controller.sv
// Scoreboard bench for audio_capture_controller with an 8-deep frame.
module tb_audio_capture_controller;

   localparam int SW = 8;
   localparam int D  = 8;
   localparam int DW = 8;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 start = 1'b0;
   logic                 abort = 1'b0;
   logic                 trig_enable = 1'b0;
   logic signed [SW-1:0] trig_level = '0;
   logic [DW-1:0]        decim = 8'd1;
   logic                 sample_valid = 1'b0;
   logic signed [SW-1:0] sample_data = '0;
   logic                 bram_we;
   logic [2:0]           bram_addr;
   logic signed [SW-1:0] bram_din;
   logic                 busy;
   logic                 done;
   logic [15:0]          frame_count;

   typedef struct {
      int addr;
      int data;
   } wr_t;

   wr_t exp_wr[$];
   int  exp_done[$];
   int  checks = 0;
   int  errors = 0;

   audio_capture_controller #(
      .SAMPLE_DATA_WIDTH(SW),
      .DEPTH            (D),
      .DECIM_WIDTH      (DW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .abort       (abort),
      .trig_enable (trig_enable),
      .trig_level  (trig_level),
      .decim       (decim),
      .sample_valid(sample_valid),
      .sample_data (sample_data),
      .bram_we     (bram_we),
      .bram_addr   (bram_addr),
      .bram_din    (bram_din),
      .busy        (busy),
      .done        (done),
      .frame_count (frame_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // Monitor: compares every presented write and done pulse against the queues
   initial begin
      wr_t w;
      forever begin
         @(negedge clk);
         if (bram_we) begin
            if (exp_wr.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: addr %0d data %0d, expected no write", bram_addr, bram_din);
            end else begin
               w = exp_wr.pop_front();
               check("write_addr", int'(bram_addr), w.addr);
               check("write_data", int'(bram_din), w.data);
            end
         end
         if (done) begin
            if (exp_done.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: frame_count %0d, expected no done", frame_count);
            end else begin
               check("done_frame_count", int'(frame_count), exp_done.pop_front());
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic te, input int lvl, input int dec);
      trig_enable = te;
      trig_level  = SW'(lvl);
      decim       = DW'(dec);
      start       = 1'b1;
      tick();
      start       = 1'b0;
   endtask

   task automatic send(input int d);
      sample_data  = SW'(d);
      sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
   endtask

   task automatic expect_wr(input int a, input int d);
      wr_t w;
      w.addr = a;
      w.data = d;
      exp_wr.push_back(w);
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while ((busy || done) && n < 100) begin
         tick();
         n++;
      end
      tick();
      check({name, "_idle_timeout"}, int'(n >= 100), 0);
      check({name, "_writes_left"}, exp_wr.size(), 0);
      check({name, "_dones_left"}, exp_done.size(), 0);
   endtask

   initial begin
      repeat (3) tick();
      check("rst_we", int'(bram_we), 0);
      check("rst_addr", int'(bram_addr), 0);
      check("rst_din", int'(bram_din), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_frame_count", int'(frame_count), 0);
      rst = 1'b0;
      tick();

      // free-run ramp
      do_start(1'b0, 0, 1);
      check("freerun_busy", int'(busy), 1);
      exp_done.push_back(1);
      for (int i = 0; i < 8; i++) begin
         expect_wr(i, i);
         send(i);
      end
      check("last_write_visible", int'(bram_we), 1);
      tick();
      check("done_after_last_write", int'(done), 1);
      check("busy_in_done", int'(busy), 0);
      wait_idle("freerun");
      check("freerun_frame_count", int'(frame_count), 1);

      // triggered capture
      do_start(1'b1, 10, 1);
      send(-5);
      send(5);
      send(9);
      check("armed_busy", int'(busy), 1);
      expect_wr(0, 12);
      send(12);
      expect_wr(1, 20);
      send(20);
      exp_done.push_back(2);
      for (int i = 0; i < 6; i++) begin
         expect_wr(i + 2, 30 + i);
         send(30 + i);
      end
      wait_idle("trigger");

      // decimation by 3, then decim=0 behaves as 1
      do_start(1'b0, 0, 3);
      exp_done.push_back(3);
      for (int i = 0; i < 24; i++) begin
         if (i % 3 == 0) expect_wr(i / 3, i);
         send(i);
      end
      wait_idle("decim3");
      do_start(1'b0, 0, 0);
      exp_done.push_back(4);
      for (int i = 0; i < 8; i++) begin
         expect_wr(i, 40 + i);
         send(40 + i);
      end
      wait_idle("decim0");

      // abort after 3 writes, then restart from addr 0
      do_start(1'b0, 0, 1);
      for (int i = 0; i < 3; i++) begin
         expect_wr(i, 50 + i);
         send(50 + i);
      end
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_busy", int'(busy), 0);
      check("abort_frame_count", int'(frame_count), 4);
      repeat (5) tick();
      do_start(1'b0, 0, 1);
      exp_done.push_back(5);
      for (int i = 0; i < 8; i++) begin
         expect_wr(i, 100 + i);
         send(100 + i);
      end
      wait_idle("restart");

      // start pulses while busy and samples in IDLE are ignored
      do_start(1'b1, 50, 1);
      send(10);
      trig_enable = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("start_in_armed_busy", int'(busy), 1);
      send(20);
      expect_wr(0, 60);
      send(60);
      start = 1'b1;
      tick();
      start = 1'b0;
      expect_wr(1, 70);
      send(70);
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort2_busy", int'(busy), 0);
      send(5);
      send(6);
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      check("abort_beats_start", int'(busy), 0);
      check("ignored_frame_count", int'(frame_count), 5);

      // reset mid-capture
      do_start(1'b0, 0, 1);
      expect_wr(0, 1);
      send(1);
      expect_wr(1, 2);
      send(2);
      rst = 1'b1;
      tick();
      check("midrst_we", int'(bram_we), 0);
      check("midrst_addr", int'(bram_addr), 0);
      check("midrst_din", int'(bram_din), 0);
      check("midrst_busy", int'(busy), 0);
      check("midrst_done", int'(done), 0);
      check("midrst_frame_count", int'(frame_count), 0);
      rst = 1'b0;
      repeat (3) tick();
      check("final_writes_left", exp_wr.size(), 0);
      check("final_dones_left", exp_done.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
